nested_irq_ctrl: RTL
====================

Name: nested_irq_ctrl

Overview:
Prioritised, nestable interrupt controller that sequences the pipeline's three-line interrupt resource.
- Latches break requests and arbitrates them against the current service level and the CP0 mask.
- Issues a one-cycle `interrupt` flush pulse with vector address, and keeps an EPC/level stack so higher-priority requests preempt running ISRs and `eret` unwinds correctly.
- Sits beside IF/pipeline registers: drives their `interrupt` flush input and IF's `isr_entry`; consumes `eret` from the EX/MEM register and the WB-stage next-PC.

Parameters:
NUM_IRQ, 3, number of request lines; index NUM_IRQ-1 is highest priority
ISR_BASE, 32'h0000_1000, vector address of line 0
ISR_STRIDE, 32'h0000_0080, vector spacing per line
HOLDOFF, 3, cycles after a take or eret during which no new take is issued (pipeline flush window)

Ports:
clk  in  1  system clock, rising-edge
RST  in  1  asynchronous, active-low reset
break_i  in  NUM_IRQ  request lines, already synchronised; a rising edge is one request
pipe_ready  in  1  1 = no stall/bubble this cycle; a take is allowed
eret  in  1  eret reached EX/MEM stage, one-cycle pulse
npc_wb  in  32  next-PC of the instruction in WB; becomes the return address
mtc0  in  1  write mask register
cp0_din  in  32  mtc0 data; bits [NUM_IRQ-1:0] = enable mask
cp0_dout  out  32  {zero, cur_level[1:0] at [9:8], mask at [NUM_IRQ-1:0]}
interrupt  out  1  one-cycle flush/redirect pulse
isr_entry  out  32  vector, valid while interrupt=1, holds last value otherwise
epc  out  32  top-of-stack return address (0 when stack empty)
iw  out  NUM_IRQ  pending-and-waiting flags
ir_sig  out  NUM_IRQ  in-service flags (one bit per stacked level)
cur_level  out  2  0 = none, k+1 = servicing line k
eret_err  out  1  one-cycle pulse: eret with empty stack

Behaviour:
- Reset (RST=0, async): pend=0, prev_break=0, mask=all ones, stack empty (sp=0), cur_level=0, interrupt=0, isr_entry=ISR_BASE, epc=0, iw=0, ir_sig=0, holdoff counter=0, FSM=S_RUN, eret_err=0. Reset mid-service discards the whole stack.
- Edge capture: pend[k] sets on the cycle break_i[k]=1 and prev_break[k]=0. Further edges while set are merged. pend[k] clears only on the take of line k.
- iw = pend (registered).
- Candidate: highest k with pend[k] & mask[k] and (k+1) > cur_level.
- Take condition: FSM=S_RUN & holdoff=0 & pipe_ready & !eret & candidate exists.
- Take at edge t, combinational decision in cycle t-1:
  - interrupt=1 for exactly one cycle; isr_entry=ISR_BASE+k*ISR_STRIDE.
  - Push {npc_wb, cur_level} at stack[sp]; sp++; cur_level=k+1; ir_sig[k]=1; pend[k]=0.
  - Load holdoff=HOLDOFF.
- Minimum latency from break edge to interrupt high: 2 cycles.
- FSM: S_RUN -(take)-> S_ISSUE (interrupt=1) -> S_FLUSH (holdoff counts down 1/cycle) -(holdoff=0)-> S_RUN.
- eret in S_RUN with sp>0: pop; ir_sig[cur_level-1]=0; cur_level=popped level; epc=new top or 0; holdoff=HOLDOFF; FSM->S_FLUSH. Pending lower requests are then taken after holdoff.
- eret with sp=0: eret_err=1, no state change.
- eret in S_ISSUE/S_FLUSH: ignored. It cannot occur legally, since the flush removed it.
- Simultaneous eret and new edge: eret processed, edge still latched into pend.
- Stack depth NUM_IRQ. Overflow is impossible because level strictly increases per push, so no full check is needed.
- mtc0: mask<=cp0_din[NUM_IRQ-1:0] at edge. It affects the candidate from the next cycle only. Masked lines stay pending (iw stays 1).
- pipe_ready=0 defers the take; the request is not lost.

Decomposition:
- Package irq_pkg: NUM_IRQ default, LEVEL_W=2, FSM enum {S_RUN,S_ISSUE,S_FLUSH}, cp0_dout field offsets, ISR_BASE/ISR_STRIDE defaults.
- One sub-module: irq_prio_enc, a combinational masked highest-priority encoder. Outputs are valid flag and index, given pend, mask and cur_level.

Test Plan:
1. Single take: break_i[1] rises, cur_level=0, pipe_ready=1, npc_wb=32'h40 -> 2 cycles later interrupt=1 for 1 cycle, isr_entry=32'h1080, epc=32'h40, ir_sig=3'b010, cur_level=2, iw=0.
2. Nesting: during case 1 after holdoff, break_i[2] rises with npc_wb=32'h1088 -> isr_entry=32'h1100, epc=32'h1088, ir_sig=3'b110, cur_level=3. Then eret -> epc=32'h40, ir_sig=3'b010, cur_level=2.
3. Lower priority waits: at cur_level=2, break_i[0] rises -> iw=3'b001, no interrupt. eret pops to level 0 -> HOLDOFF cycles later interrupt=1, isr_entry=32'h1000.
4. Mask/stall: mtc0 with cp0_din=0 then break_i[2] -> iw[2]=1, no take. mtc0 cp0_din=7 with pipe_ready=0 for 4 cycles -> still no take. pipe_ready=1 -> take with isr_entry=32'h1100.
5. Error and reset: eret with empty stack -> eret_err pulse, outputs unchanged. RST low while cur_level=3 -> all outputs at reset values immediately, mask=3'b111.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the nested interrupt controller.
// Holds default parameter values, the service-level width, the CP0 status
// field offsets and the sequencing FSM state type.
package irq_pkg;

  localparam int unsigned NUM_IRQ_DEF    = 3;
  localparam int unsigned LEVEL_W        = 2;
  localparam int unsigned HOLDOFF_DEF    = 3;
  localparam logic [31:0] ISR_BASE_DEF   = 32'h0000_1000;
  localparam logic [31:0] ISR_STRIDE_DEF = 32'h0000_0080;

  // cp0_dout layout: mask at the bottom, current level at [9:8]
  localparam int unsigned CP0_MASK_LSB  = 0;
  localparam int unsigned CP0_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    S_RUN,
    S_ISSUE,
    S_FLUSH
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Masked highest-priority encoder.
// Picks the highest line k that is pending, enabled by the mask and whose
// level (k+1) is strictly above the level currently being serviced.
//   pend      : pending request flags
//   mask      : enable mask
//   cur_level : 0 = idle, k+1 = servicing line k
//   valid     : a candidate exists
//   idx       : index of the winning line (0 when !valid)
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ = NUM_IRQ_DEF,
  parameter int unsigned IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] pend,
  input  logic [NUM_IRQ-1:0] mask,
  input  logic [LEVEL_W-1:0] cur_level,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Ascending scan: the last hit is the highest-priority line.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (pend[k] && mask[k] && ((k + 1) > int'(cur_level))) begin
        valid = 1'b1;
        idx   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/nested_irq_ctrl.sv
// Prioritised, nestable interrupt controller.
// Latches request edges, arbitrates them against the service level and the
// CP0 mask, issues a one-cycle flush pulse with a vector address, and keeps an
// EPC/level stack so higher-priority requests preempt and eret unwinds.
//   clk, RST      : clock, asynchronous active-low reset
//   break_i       : request lines, rising edge = one request
//   pipe_ready    : no stall/bubble this cycle, a take is allowed
//   eret          : eret at EX/MEM, one-cycle pulse
//   npc_wb        : WB-stage next-PC, pushed as return address
//   mtc0, cp0_din : mask register write
//   cp0_dout      : {level at [9:8], mask at [NUM_IRQ-1:0]}
//   interrupt     : one-cycle flush/redirect pulse
//   isr_entry     : vector of the last take
//   epc           : top-of-stack return address, 0 when empty
//   iw, ir_sig    : pending-and-waiting / in-service flags
//   cur_level     : 0 = none, k+1 = servicing line k
//   eret_err      : one-cycle pulse on eret with an empty stack
module nested_irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = NUM_IRQ_DEF,
  parameter logic [31:0] ISR_BASE   = ISR_BASE_DEF,
  parameter logic [31:0] ISR_STRIDE = ISR_STRIDE_DEF,
  parameter int unsigned HOLDOFF    = HOLDOFF_DEF
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] break_i,
  input  logic               pipe_ready,
  input  logic               eret,
  input  logic [31:0]        npc_wb,
  input  logic               mtc0,
  input  logic [31:0]        cp0_din,
  output logic [31:0]        cp0_dout,
  output logic               interrupt,
  output logic [31:0]        isr_entry,
  output logic [31:0]        epc,
  output logic [NUM_IRQ-1:0] iw,
  output logic [NUM_IRQ-1:0] ir_sig,
  output logic [LEVEL_W-1:0] cur_level,
  output logic               eret_err
);

  localparam int unsigned IdxW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned SpW  = $clog2(NUM_IRQ + 1);
  localparam int unsigned HoW  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  irq_state_e         state_q, state_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] prev_break_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] ir_sig_q, ir_sig_d;
  logic [LEVEL_W-1:0] cur_level_q, cur_level_d;
  logic [SpW-1:0]     sp_q, sp_d;
  logic [HoW-1:0]     holdoff_q, holdoff_d;
  logic [31:0]        isr_entry_q, isr_entry_d;
  logic               eret_err_q, eret_err_d;
  logic [31:0]        stk_pc_q  [NUM_IRQ];
  logic [LEVEL_W-1:0] stk_lvl_q [NUM_IRQ];

  logic               cand_valid;
  logic [IdxW-1:0]    cand_idx;
  logic               take, pop;
  logic [31:0]        top_pc;
  logic [LEVEL_W-1:0] top_lvl;
  logic               unused_cp0;

  assign unused_cp0 = ^cp0_din[31:NUM_IRQ];

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IdxW)
  ) u_prio_enc (
    .pend      (pend_q),
    .mask      (mask_q),
    .cur_level (cur_level_q),
    .valid     (cand_valid),
    .idx       (cand_idx)
  );

  // Top-of-stack view; sp_q = 0 yields zeros, which is the empty epc value.
  always_comb begin
    top_pc  = '0;
    top_lvl = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (sp_q == SpW'(i + 1)) begin
        top_pc  = stk_pc_q[i];
        top_lvl = stk_lvl_q[i];
      end
    end
  end

  // Sequencing FSM: take / eret decisions and the holdoff window.
  always_comb begin
    state_d    = state_q;
    holdoff_d  = holdoff_q;
    take       = 1'b0;
    pop        = 1'b0;
    eret_err_d = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (eret) begin
          if (sp_q != '0) begin
            pop       = 1'b1;
            holdoff_d = HoW'(HOLDOFF);
            state_d   = S_FLUSH;
          end else begin
            eret_err_d = 1'b1;
          end
        end else if ((holdoff_q == '0) && pipe_ready && cand_valid) begin
          take      = 1'b1;
          holdoff_d = HoW'(HOLDOFF);
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_FLUSH;
      S_FLUSH: begin
        // Leaving on the last count keeps exactly HOLDOFF blocked cycles.
        if (holdoff_q <= HoW'(1)) begin
          holdoff_d = '0;
          state_d   = S_RUN;
        end else begin
          holdoff_d = holdoff_q - HoW'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // Datapath next state driven by take / pop.
  always_comb begin
    pend_d      = pend_q | (break_i & ~prev_break_q);
    ir_sig_d    = ir_sig_q;
    cur_level_d = cur_level_q;
    sp_d        = sp_q;
    isr_entry_d = isr_entry_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      // A merged edge on the line being taken is absorbed by the take.
      if (take && (cand_idx == IdxW'(i))) begin
        pend_d[i]   = 1'b0;
        ir_sig_d[i] = 1'b1;
      end
      if (pop && (cur_level_q == LEVEL_W'(i + 1))) begin
        ir_sig_d[i] = 1'b0;
      end
    end
    if (take) begin
      cur_level_d = LEVEL_W'(cand_idx) + LEVEL_W'(1);
      sp_d        = sp_q + SpW'(1);
      isr_entry_d = ISR_BASE + ISR_STRIDE * 32'(cand_idx);
    end else if (pop) begin
      cur_level_d = top_lvl;
      sp_d        = sp_q - SpW'(1);
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q      <= S_RUN;
      pend_q       <= '0;
      prev_break_q <= '0;
      mask_q       <= '1;
      ir_sig_q     <= '0;
      cur_level_q  <= '0;
      sp_q         <= '0;
      holdoff_q    <= '0;
      isr_entry_q  <= ISR_BASE;
      eret_err_q   <= 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) begin
        stk_pc_q[i]  <= '0;
        stk_lvl_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      prev_break_q <= break_i;
      ir_sig_q     <= ir_sig_d;
      cur_level_q  <= cur_level_d;
      sp_q         <= sp_d;
      holdoff_q    <= holdoff_d;
      isr_entry_q  <= isr_entry_d;
      eret_err_q   <= eret_err_d;
      if (mtc0) begin
        mask_q <= cp0_din[NUM_IRQ-1:0];
      end
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (take && (sp_q == SpW'(i))) begin
          stk_pc_q[i]  <= npc_wb;
          stk_lvl_q[i] <= cur_level_q;
        end
      end
    end
  end

  always_comb begin
    cp0_dout = '0;
    cp0_dout[CP0_MASK_LSB +: NUM_IRQ]  = mask_q;
    cp0_dout[CP0_LEVEL_LSB +: LEVEL_W] = cur_level_q;
  end

  assign interrupt = (state_q == S_ISSUE);
  assign isr_entry = isr_entry_q;
  assign epc       = top_pc;
  assign iw        = pend_q;
  assign ir_sig    = ir_sig_q;
  assign cur_level = cur_level_q;
  assign eret_err  = eret_err_q;

endmodule
